// File: rtl/subcode_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : subcode_frame_sequencer
// Description : Tracks the subcode block sync (an S0 frame followed by an S1
//               frame). Runs a search/verify/lock/flywheel state machine,
//               numbers each frame within its block and forwards frames to
//               the C1 decoder over valid/ready, but only while in sync.
// Revision    : 1.0 - initial release
// ============================================================================
module subcode_frame_sequencer #(
    parameter int BLOCK_FRAMES  = 98,
    parameter int LOCK_COUNT    = 2,
    parameter int MISS_LIMIT    = 3,
    parameter int FRAME_TIMEOUT = 4096
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         frame_valid,
    input  logic [263:0] frame_words,
    input  logic         in_s0,
    input  logic         in_s1,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [263:0] out_words,
    output logic [6:0]   out_index,
    output logic         out_block_start,
    output logic [1:0]   sync_state,
    output logic         locked,
    output logic         timeout_err,
    output logic [7:0]   drop_count
);

    localparam logic [1:0] c_SEARCH   = 2'd0;
    localparam logic [1:0] c_VERIFY   = 2'd1;
    localparam logic [1:0] c_LOCKED   = 2'd2;
    localparam logic [1:0] c_FLYWHEEL = 2'd3;

    localparam int                 c_TMO_W    = $clog2(FRAME_TIMEOUT + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_MAX  = c_TMO_W'(FRAME_TIMEOUT);
    localparam logic [6:0]         c_IDX_LAST = 7'(BLOCK_FRAMES - 1);
    localparam logic [3:0]         c_LOCK_CNT = 4'(LOCK_COUNT);
    localparam logic [3:0]         c_MISS_LIM = 4'(MISS_LIMIT);

    logic [1:0]         state_q, state_d;
    logic [6:0]         idx_q, idx_d;
    logic [3:0]         good_q, good_d;
    logic [3:0]         miss_q, miss_d;
    logic               s0_prev_q, s0_prev_d;
    logic [c_TMO_W-1:0] tmo_q, tmo_d;
    logic               tmo_err_q, tmo_err_d;
    logic               out_valid_q, out_valid_d;
    logic [263:0]       out_words_q, out_words_d;
    logic [6:0]         out_index_q, out_index_d;
    logic               out_start_q, out_start_d;
    logic [7:0]         drop_q, drop_d;

    logic [6:0]         w_idx_inc;
    logic [3:0]         w_good_inc;
    logic [3:0]         w_miss_inc;
    logic [c_TMO_W-1:0] w_tmo_inc;
    logic               w_pair;
    logic               w_checkpoint;

    assign w_idx_inc    = (idx_q == c_IDX_LAST) ? 7'd0 : idx_q + 7'd1;
    assign w_good_inc   = good_q + 4'd1;
    assign w_miss_inc   = miss_q + 4'd1;
    assign w_tmo_inc    = tmo_q + {{(c_TMO_W-1){1'b0}}, 1'b1};
    assign w_pair       = in_s1 && s0_prev_q;
    assign w_checkpoint = (w_idx_inc == 7'd1);

    // Sync state machine, frame numbering and idle-timeout supervision
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        good_d    = good_q;
        miss_d    = miss_q;
        s0_prev_d = s0_prev_q;
        tmo_d     = tmo_q;
        tmo_err_d = 1'b0;
        if (frame_valid) begin
            tmo_d     = '0;
            s0_prev_d = in_s0;
            case (state_q)
                c_SEARCH: begin
                    idx_d = 7'd0;
                    if (w_pair) begin
                        state_d = c_VERIFY;
                        idx_d   = 7'd1;
                        good_d  = 4'd1;
                    end
                end
                c_VERIFY: begin
                    idx_d = w_idx_inc;
                    if (w_checkpoint) begin
                        if (w_pair) begin
                            good_d = w_good_inc;
                            if (w_good_inc == c_LOCK_CNT) begin
                                state_d = c_LOCKED;
                            end
                        end else begin
                            state_d = c_SEARCH;
                            idx_d   = 7'd0;
                            good_d  = 4'd0;
                        end
                    end else if (w_pair) begin
                        // A pair in the wrong place re-anchors the block
                        idx_d  = 7'd1;
                        good_d = 4'd1;
                    end
                end
                c_LOCKED: begin
                    idx_d = w_idx_inc;
                    if (w_checkpoint && !w_pair) begin
                        state_d = c_FLYWHEEL;
                        miss_d  = 4'd1;
                    end
                end
                default: begin
                    idx_d = w_idx_inc;
                    if (w_checkpoint) begin
                        if (w_pair) begin
                            state_d = c_LOCKED;
                            miss_d  = 4'd0;
                        end else begin
                            miss_d = w_miss_inc;
                            if (w_miss_inc == c_MISS_LIM) begin
                                state_d = c_SEARCH;
                                idx_d   = 7'd0;
                                miss_d  = 4'd0;
                                good_d  = 4'd0;
                            end
                        end
                    end
                end
            endcase
        end else if (w_tmo_inc == c_TMO_MAX) begin
            state_d   = c_SEARCH;
            idx_d     = 7'd0;
            good_d    = 4'd0;
            miss_d    = 4'd0;
            tmo_d     = '0;
            tmo_err_d = 1'b1;
        end else begin
            tmo_d = w_tmo_inc;
        end
    end

    // Output register: load when free or being drained, otherwise drop and count
    always_comb begin
        out_valid_d = out_valid_q;
        out_words_d = out_words_q;
        out_index_d = out_index_q;
        out_start_d = out_start_q;
        drop_d      = drop_q;
        if (frame_valid && state_d[1]) begin
            if (!out_valid_q || out_ready) begin
                out_valid_d = 1'b1;
                out_words_d = frame_words;
                out_index_d = idx_d;
                out_start_d = (idx_d == 7'd0);
            end else if (drop_q != 8'hFF) begin
                drop_d = drop_q + 8'd1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State and output flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= c_SEARCH;
            idx_q       <= 7'd0;
            good_q      <= 4'd0;
            miss_q      <= 4'd0;
            s0_prev_q   <= 1'b0;
            tmo_q       <= '0;
            tmo_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_words_q <= '0;
            out_index_q <= 7'd0;
            out_start_q <= 1'b0;
            drop_q      <= 8'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            good_q      <= good_d;
            miss_q      <= miss_d;
            s0_prev_q   <= s0_prev_d;
            tmo_q       <= tmo_d;
            tmo_err_q   <= tmo_err_d;
            out_valid_q <= out_valid_d;
            out_words_q <= out_words_d;
            out_index_q <= out_index_d;
            out_start_q <= out_start_d;
            drop_q      <= drop_d;
        end
    end

    assign out_valid       = out_valid_q;
    assign out_words       = out_words_q;
    assign out_index       = out_index_q;
    assign out_block_start = out_start_q;
    assign sync_state      = state_q;
    assign locked          = state_q[1];
    assign timeout_err     = tmo_err_q;
    assign drop_count      = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_subcode_frame_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_subcode_frame_sequencer
// Description : Directed self-checking bench for subcode_frame_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_subcode_frame_sequencer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         frame_valid;
    logic [263:0] frame_words;
    logic         in_s0;
    logic         in_s1;
    logic         out_valid;
    logic         out_ready;
    logic [263:0] out_words;
    logic [6:0]   out_index;
    logic         out_block_start;
    logic [1:0]   sync_state;
    logic         locked;
    logic         timeout_err;
    logic [7:0]   drop_count;

    int checks = 0;
    int errors = 0;
    int ph = 0;        // position of the next frame within the stimulus block
    int fn = 0;        // serial number of the next frame
    int last_fn = 0;
    int first_fn = 0;
    int first_ph = 0;
    int pulses = 0;
    int first_pulse = -1;

    always #5 clk = ~clk;

    subcode_frame_sequencer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .frame_valid     (frame_valid),
        .frame_words     (frame_words),
        .in_s0           (in_s0),
        .in_s1           (in_s1),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_words       (out_words),
        .out_index       (out_index),
        .out_block_start (out_block_start),
        .sync_state      (sync_state),
        .locked          (locked),
        .timeout_err     (timeout_err),
        .drop_count      (drop_count)
    );

    function automatic logic [263:0] mk(input int n);
        logic [7:0] b;
        b = n[7:0];
        return {33{b}};
    endfunction

    task automatic check(input string tag, input logic [263:0] got, input logic [263:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One frame for one cycle; returns at the following negedge
    task automatic send_f(input logic s0, input logic s1);
        frame_valid = 1'b1;
        in_s0       = s0;
        in_s1       = s1;
        frame_words = mk(fn);
        @(negedge clk);
        frame_valid = 1'b0;
        in_s0       = 1'b0;
        in_s1       = 1'b0;
        last_fn     = fn;
        fn++;
        ph = (ph + 1) % 98;
    endtask

    task automatic send(input logic s1_en);
        send_f(ph == 0, (ph == 1) && s1_en);
    endtask

    task automatic run_to(input int target);
        while (ph != target) send(1'b1);
    endtask

    initial begin
        rst_n       = 1'b0;
        frame_valid = 1'b0;
        frame_words = '0;
        in_s0       = 1'b0;
        in_s1       = 1'b0;
        out_ready   = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_state", sync_state, 0);
        check("rst_locked", locked, 0);
        check("rst_drop", drop_count, 0);
        check("rst_words", out_words, 0);
        check("rst_timeout", timeout_err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Acquisition: VERIFY after first pair, LOCKED at frame 99
        send(1'b1);
        send(1'b1);
        check("verify_after_pair", sync_state, 1);
        run_to(0);
        check("no_out_before_lock", out_valid, 0);
        check("still_verify", sync_state, 1);
        send(1'b1);
        send(1'b1);
        check("lock_state", sync_state, 2);
        check("lock_flag", locked, 1);
        check("first_out_valid", out_valid, 1);
        check("first_out_index", out_index, 1);
        check("first_out_words", out_words, mk(99));
        check("first_block_start", out_block_start, 0);

        // Spurious pair at 50 is ignored; back-to-back frames keep OUT_VALID high
        run_to(49);
        send_f(1'b1, 1'b0);
        send_f(1'b0, 1'b1);
        check("spurious_state", sync_state, 2);
        check("spurious_index", out_index, 50);
        check("b2b_valid", out_valid, 1);
        check("b2b_words50", out_words, mk(last_fn));
        send(1'b1);
        check("after_spur_index", out_index, 51);
        check("b2b_words51", out_words, mk(last_fn));
        run_to(0);
        send(1'b1);
        check("block_start_idx0", out_block_start, 1);

        // Flywheel then restore
        send(1'b0);
        check("flywheel_1", sync_state, 3);
        check("flywheel_locked", locked, 1);
        check("flywheel_out", out_valid, 1);
        check("flywheel_index", out_index, 1);
        run_to(0);
        send(1'b1);
        send(1'b1);
        check("restore_lock", sync_state, 2);

        // Three misses drop to SEARCH
        run_to(0);
        send(1'b1);
        send(1'b0);
        check("miss1", sync_state, 3);
        run_to(0);
        send(1'b1);
        send(1'b0);
        check("miss2", sync_state, 3);
        run_to(0);
        send(1'b1);
        send(1'b0);
        check("miss3_state", sync_state, 0);
        check("miss3_locked", locked, 0);
        check("miss3_out", out_valid, 0);
        send(1'b1);
        check("search_no_out", out_valid, 0);

        // Reacquire
        run_to(0);
        send(1'b1);
        send(1'b1);
        check("reverify", sync_state, 1);
        run_to(0);
        send(1'b1);
        send(1'b1);
        check("relock", sync_state, 2);

        // Back-pressure: 300 frames with OUT_READY low
        repeat (2) @(negedge clk);
        check("drained", out_valid, 0);
        out_ready = 1'b0;
        first_fn  = fn;
        first_ph  = ph;
        send(1'b1);
        repeat (299) send(1'b1);
        check("drop_sat", drop_count, 255);
        check("stall_valid", out_valid, 1);
        check("stall_words", out_words, mk(first_fn));
        check("stall_index", out_index, first_ph);
        check("stall_state", sync_state, 2);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("accept_stalled", out_valid, 0);
        check("drop_hold", drop_count, 255);
        send(1'b1);
        check("reload_valid", out_valid, 1);
        check("reload_words", out_words, mk(last_fn));

        // Idle timeout with a frame parked in the output register
        for (int i = 1; i <= 4200; i++) begin
            @(negedge clk);
            if (timeout_err) begin
                pulses++;
                if (first_pulse < 0) first_pulse = i;
            end
        end
        check("timeout_pulses", pulses, 1);
        check("timeout_cycle", (first_pulse >= 4095) && (first_pulse <= 4098), 1);
        check("timeout_state", sync_state, 0);
        check("timeout_locked", locked, 0);
        check("timeout_out_kept", out_valid, 1);
        check("timeout_words_kept", out_words, mk(last_fn));

        // Asynchronous reset clears everything immediately
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_words", out_words, 0);
        check("arst_index", out_index, 0);
        check("arst_state", sync_state, 0);
        check("arst_drop", drop_count, 0);
        check("arst_locked", locked, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
